// File: rtl/alu_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_arb_pkg                                                           |
// | Shared ALU control codes and state encodings for alu_arbiter.         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package alu_arb_pkg;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;

   typedef enum logic [0:0] {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } alu_op_e;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_e;

endpackage : alu_arb_pkg
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu                                                                   |
// | 32-bit add/subtract datapath; carry and borrow are discarded.         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module alu
   import alu_arb_pkg::*;
(
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic [2:0]  alu_control,
   output logic [31:0] alu_result
);

   always_comb begin
      alu_result = '0;
      case (alu_control)
         ALU_ADD: alu_result = src_a + src_b;
         ALU_SUB: alu_result = src_a - src_b;
         default: alu_result = '0;
      endcase
   end

endmodule : alu
`default_nettype wire

// File: rtl/alu_arbiter_rr.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_arbiter                                                            |
// | Round-robin priority search starting at ptr; one-hot grant + index.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx
);

   logic           w_found;
   logic [IDW-1:0] w_k;

   always_comb begin
      gnt     = '0;
      idx     = '0;
      w_found = 1'b0;
      w_k     = '0;
      // Walk ptr, ptr+1, ... modulo NREQ; the first asserted request wins.
      for (int i = 0; i < NREQ; i++) begin
         w_k = IDW'((int'(ptr) + i) % NREQ);
         if (en && !w_found && req[w_k]) begin
            w_found  = 1'b1;
            gnt[w_k] = 1'b1;
            idx      = w_k;
         end
      end
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_arbiter                                                           |
// | Round-robin sharing of one add/sub ALU with a one-entry result slot.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0]       req_op,
   input  logic [NREQ-1:0][31:0] req_a,
   input  logic [NREQ-1:0][31:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [31:0]           rsp_result,
   output logic [15:0]           op_count
);

   slot_state_e    r_state, w_next_state;
   logic [IDW-1:0] r_rr_ptr;
   logic [IDW-1:0] r_rsp_id;
   logic [31:0]    r_rsp_result;
   logic [15:0]    r_op_count;

   logic            w_slot_free;
   logic            w_accept;
   logic            w_drain;
   logic [NREQ-1:0] w_gnt;
   logic [IDW-1:0]  w_gnt_idx;
   logic [2:0]      w_alu_control;
   logic [31:0]     w_alu_result;

   assign w_slot_free = (r_state == EMPTY) || rsp_ready;
   assign w_drain     = (r_state == FULL) && rsp_ready;
   // The arbiter only grants asserted requests, so any grant is an accept.
   assign w_accept    = |w_gnt;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_arbiter (
      .req (req_valid),
      .ptr (r_rr_ptr),
      .en  (w_slot_free),
      .gnt (w_gnt),
      .idx (w_gnt_idx)
   );

   assign w_alu_control = (alu_op_e'(req_op[w_gnt_idx]) == OP_SUB) ? ALU_SUB : ALU_ADD;

   alu u_alu (
      .src_a       (req_a[w_gnt_idx]),
      .src_b       (req_b[w_gnt_idx]),
      .alu_control (w_alu_control),
      .alu_result  (w_alu_result)
   );

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         EMPTY:   if (w_accept) w_next_state = FULL;
         FULL:    if (!w_accept && rsp_ready) w_next_state = EMPTY;
         default: w_next_state = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= EMPTY;
         r_rr_ptr     <= '0;
         r_rsp_id     <= '0;
         r_rsp_result <= '0;
         r_op_count   <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_rsp_result <= w_alu_result;
            r_rsp_id     <= w_gnt_idx;
            r_rr_ptr     <= (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);
         end
         if (w_drain && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
         end
      end
   end

   assign req_ready  = w_gnt;
   assign rsp_valid  = (r_state == FULL);
   assign rsp_id     = r_rsp_id;
   assign rsp_result = r_rsp_result;
   assign op_count   = r_op_count;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// Directed self-checking bench: NREQ=2 instance for the main flow,
// NREQ=4 instance for the sparse-request fairness case.
module tb_alu_arbiter;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       v2, op2, rdy2;
   logic [1:0][31:0] a2, b2;
   logic             rr2, rv2;
   logic [0:0]       rid2;
   logic [31:0]      res2;
   logic [15:0]      cnt2;

   logic [3:0]       v4, op4, rdy4;
   logic [3:0][31:0] a4, b4;
   logic             rr4, rv4;
   logic [1:0]       rid4;
   logic [31:0]      res4;
   logic [15:0]      cnt4;

   int checks = 0;
   int errors = 0;

   alu_arbiter #(.NREQ(2)) dut2 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(v2), .req_op(op2), .req_a(a2), .req_b(b2), .req_ready(rdy2),
      .rsp_valid(rv2), .rsp_ready(rr2), .rsp_id(rid2), .rsp_result(res2),
      .op_count(cnt2)
   );

   alu_arbiter #(.NREQ(4)) dut4 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(v4), .req_op(op4), .req_a(a4), .req_b(b4), .req_ready(rdy4),
      .rsp_valid(rv4), .rsp_ready(rr4), .rsp_id(rid4), .rsp_result(res4),
      .op_count(cnt4)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      v2 = '0; op2 = '0; a2 = '0; b2 = '0; rr2 = 1'b0;
      v4 = '0; op4 = '0; a4 = '0; b4 = '0; rr4 = 1'b0;

      // Reset values
      #12;
      chk("reset_rsp_valid", 64'(rv2), 64'd0);
      chk("reset_rsp_id", 64'(rid2), 64'd0);
      chk("reset_rsp_result", 64'(res2), 64'd0);
      chk("reset_op_count", 64'(cnt2), 64'd0);
      chk("reset_req_ready", 64'(rdy2), 64'd0);
      tick();
      reset_n = 1'b1;

      // Single add on requester 0: 5 + 7
      v2 = 2'b01; op2 = 2'b00; a2[0] = 32'd5; b2[0] = 32'd7;
      #1 chk("add_ready", 64'(rdy2), 64'b01);
      tick();
      v2 = 2'b00;
      chk("add_valid", 64'(rv2), 64'd1);
      chk("add_result", 64'(res2), 64'd12);
      chk("add_id", 64'(rid2), 64'd0);

      // Single sub on requester 1: 3 - 5, offered while the slot is held
      v2 = 2'b10; op2 = 2'b10; a2[1] = 32'd3; b2[1] = 32'd5;
      #1 chk("full_blocks_ready", 64'(rdy2), 64'd0);
      rr2 = 1'b1;
      #1 chk("sub_ready", 64'(rdy2), 64'b10);
      tick();
      v2 = 2'b00;
      chk("sub_result", 64'(res2), 64'hFFFF_FFFE);
      chk("sub_id", 64'(rid2), 64'd1);
      chk("sub_count", 64'(cnt2), 64'd1);
      tick();
      chk("drain_empty", 64'(rv2), 64'd0);
      chk("drain_count", 64'(cnt2), 64'd2);

      // Round robin: both valid, req0 = 10+1, req1 = 20-3
      a2[0] = 32'd10; b2[0] = 32'd1; a2[1] = 32'd20; b2[1] = 32'd3; op2 = 2'b10;
      v2 = 2'b11;
      for (int i = 0; i < 8; i++) begin
         #1 chk("rr_ready", 64'(rdy2), (i % 2 == 0) ? 64'b01 : 64'b10);
         tick();
         chk("rr_valid", 64'(rv2), 64'd1);
         chk("rr_id", 64'(rid2), 64'(i % 2));
         chk("rr_result", 64'(res2), (i % 2 == 0) ? 64'd11 : 64'd17);
      end
      v2 = 2'b00;
      chk("rr_count_mid", 64'(cnt2), 64'd9);
      tick();
      chk("rr_count_end", 64'(cnt2), 64'd10);
      chk("rr_empty", 64'(rv2), 64'd0);

      // Wrap + backpressure
      rr2 = 1'b0;
      v2 = 2'b01; op2 = 2'b00; a2[0] = 32'hFFFF_FFFF; b2[0] = 32'd1;
      #1 chk("wrap_ready", 64'(rdy2), 64'b01);
      tick();
      chk("wrap_result", 64'(res2), 64'd0);
      v2 = 2'b10; op2 = 2'b10; a2[1] = 32'd0; b2[1] = 32'd1;
      for (int i = 0; i < 5; i++) begin
         #1 chk("bp_ready", 64'(rdy2), 64'd0);
         tick();
         chk("bp_valid", 64'(rv2), 64'd1);
         chk("bp_result", 64'(res2), 64'd0);
         chk("bp_id", 64'(rid2), 64'd0);
         chk("bp_count", 64'(cnt2), 64'd10);
      end
      rr2 = 1'b1;
      #1 chk("bp_release_ready", 64'(rdy2), 64'b10);
      tick();
      v2 = 2'b00;
      chk("bp_swap_valid", 64'(rv2), 64'd1);
      chk("bp_swap_result", 64'(res2), 64'hFFFF_FFFF);
      chk("bp_swap_id", 64'(rid2), 64'd1);
      chk("bp_swap_count", 64'(cnt2), 64'd11);
      tick();
      chk("bp_final_count", 64'(cnt2), 64'd12);

      // Reset while FULL with pointer advanced to 1
      rr2 = 1'b0;
      v2 = 2'b01; op2 = 2'b00; a2[0] = 32'd5; b2[0] = 32'd7;
      tick();
      v2 = 2'b00;
      chk("pre_reset_full", 64'(rv2), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(rv2), 64'd0);
      chk("midrst_id", 64'(rid2), 64'd0);
      chk("midrst_result", 64'(res2), 64'd0);
      chk("midrst_count", 64'(cnt2), 64'd0);
      chk("midrst_ready", 64'(rdy2), 64'd0);
      tick();
      reset_n = 1'b1;
      v2 = 2'b11; rr2 = 1'b1; op2 = 2'b00;
      #1 chk("post_reset_grant", 64'(rdy2), 64'b01);
      tick();
      chk("post_reset_id", 64'(rid2), 64'd0);
      chk("post_reset_count", 64'(cnt2), 64'd0);

      // Saturation: every further edge drains one result
      for (int i = 0; i < 65534; i++) tick();
      chk("sat_preload", 64'(cnt2), 64'hFFFE);
      tick();
      chk("sat_hit", 64'(cnt2), 64'hFFFF);
      tick();
      tick();
      chk("sat_hold", 64'(cnt2), 64'hFFFF);
      v2 = 2'b00;

      // NREQ=4: req1 = 9-4, req3 = 0x80000000+0x80000000
      rr4 = 1'b1;
      op4 = 4'b0010; a4[1] = 32'd9; b4[1] = 32'd4;
      a4[3] = 32'h8000_0000; b4[3] = 32'h8000_0000;
      v4 = 4'b0010;
      #1 chk("n4_setup_ready", 64'(rdy4), 64'b0010);
      tick();
      chk("n4_setup_id", 64'(rid4), 64'd1);
      v4 = 4'b1010;
      #1 chk("n4_g1_ready", 64'(rdy4), 64'b1000);
      tick();
      chk("n4_g1_id", 64'(rid4), 64'd3);
      chk("n4_g1_result", 64'(res4), 64'd0);
      #1 chk("n4_g2_ready", 64'(rdy4), 64'b0010);
      tick();
      chk("n4_g2_id", 64'(rid4), 64'd1);
      chk("n4_g2_result", 64'(res4), 64'd5);
      #1 chk("n4_g3_ready", 64'(rdy4), 64'b1000);
      tick();
      chk("n4_g3_id", 64'(rid4), 64'd3);
      chk("n4_count", 64'(cnt4), 64'd3);
      v4 = 4'b0000;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_alu_arbiter
`default_nettype wire
